game_sequencer: RTL
===================

Name: game_sequencer

Overview:
Top-level play controller for the 16x16 LED Flappy Bird game. Sequences the bird and pipe datapaths: emits scroll, fall, rise and spawn strobes, detects bird/pipe collision, and keeps a two-digit BCD score. Sits between the input debouncers and the bird/pipe shift-register modules, and drives the score display and game-over logic.

Parameters:
SCROLL_DIV, 12500000, Clock cycles per pipe scroll step (minimum 2)
FALL_DIV, 6250000, Clock cycles per bird gravity step (minimum 2)
PIPE_SPACING, 4, Scroll steps between pipe spawns (minimum 2)

Ports:
Clock  in  1  system clock
Reset_n  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse from debounced key; starts a game, or clears after game over
flap  in  1  one-cycle pulse from debounced key; bird flap request
bird  in  [15:0][15:0]  current bird bitmap
pipes  in  [15:0][15:0]  current pipe bitmap
scroll_en  out  1  one-cycle strobe: shift pipes one column
fall_en  out  1  one-cycle strobe: move bird down one row
rise_en  out  1  one-cycle strobe: move bird up one row
spawn_en  out  1  one-cycle strobe, coincident with scroll_en: insert a new pipe column
playing  out  1  high in PLAY
failed  out  1  one-cycle pulse on entry to game over
score_tens  out  4  BCD tens digit
score_ones  out  4  BCD ones digit

Behaviour:
- Clock is the single clock. Reset is synchronous and active-low (Reset_n=0 sampled at posedge). All outputs are registered.
- Reset values: state IDLE, all strobes 0, playing 0, failed 0, score 00, all counters 0.
- FSM states: IDLE, PLAY, CRASH, OVER.
  - IDLE: counters held at 0. start -> PLAY, score cleared to 00.
  - PLAY: playing=1. Collision (any bit of bird & pipes) -> CRASH.
  - CRASH: lasts one cycle; failed=1 during it; then -> OVER.
  - OVER: strobes 0; score held. start -> IDLE.
- Scroll divider counts 0..SCROLL_DIV-1 in PLAY. scroll_en=1 in the cycle after the count reaches SCROLL_DIV-1; the count then wraps to 0. First scroll_en is SCROLL_DIV cycles after PLAY entry.
- Spacing counter advances on each scroll_en and wraps at PIPE_SPACING. spawn_en accompanies the scroll_en on which it wraps, and also the first scroll_en of a game.
- Score: +1 on every spawn_en except the first of a game. BCD, ones 9->0 carries into tens. Saturates at 99.
- Fall divider behaves like the scroll divider with FALL_DIV and drives fall_en.
- flap in PLAY: rise_en=1 the next cycle. The fall divider resets to 0, so the next fall_en is FALL_DIV cycles after rise_en. rise_en and fall_en are never high together; rise_en wins.
- Simultaneous events:
  - A collision detected in a cycle suppresses every strobe that would have issued the following cycle.
  - start during PLAY or CRASH is ignored.
  - flap outside PLAY is ignored.
- Reset_n low mid-game: next edge returns to IDLE with all reset values, regardless of state.

Decomposition:
- Package game_pkg holds:
  - state enum (IDLE, PLAY, CRASH, OVER)
  - bcd_t (logic [3:0])
  - GRID = 16 constant
  - bitmap_t = logic [GRID-1:0][GRID-1:0]
- One sub-module, tick_divider: parameter DIV; inputs Clock, Reset_n, en, clr; output tick. Instantiated twice, once for scroll and once for fall.
- BCD score counter stays inline.

Test Plan:
(Bench uses SCROLL_DIV=4, FALL_DIV=3, PIPE_SPACING=2.)
- Reset_n=0 for 2 cycles, then 1 -> all outputs 0, score 00, playing 0.
- start pulse, bitmaps disjoint -> playing=1 next cycle. scroll_en every 4 cycles, first 4 cycles after PLAY entry. fall_en every 3 cycles. spawn_en on scroll steps 1,3,5,... Score 01 after the 2nd spawn.
- flap pulse in PLAY -> rise_en exactly one cycle later. No fall_en for the following 3 cycles. No cycle with rise_en and fall_en both high.
- Set bird[5][3]=pipes[5][3]=1 in PLAY -> no strobes next cycle, failed=1 for one cycle, then OVER with playing=0 and score held. A following start -> IDLE; another start -> PLAY with score 00.
- Run 200 spawns with no collision -> score reaches 99 and stays 99. Check the carry transitions 09->10 and 19->20.
- Assert Reset_n=0 mid-PLAY with score 07 -> next cycle IDLE, score 00, all strobes 0.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared types and helpers for the Flappy Bird play controller.
`default_nettype none

package game_pkg;

  localparam int GRID = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CRASH = 2'd2,
    OVER  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;
  typedef logic [GRID-1:0][GRID-1:0] bitmap_t;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input bcd_t tens, input bcd_t ones);
    if (tens == 4'd9 && ones == 4'd9) return {tens, ones};
    if (ones == 4'd9) return {tens + 4'd1, 4'd0};
    return {tens, ones + 4'd1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_sequencer_tick_divider.sv
// tick_divider: free-running modulo-DIV counter that emits a registered tick on wrap.
`default_nettype none

module tick_divider #(
  parameter int DIV = 4
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Dropping en or raising clr restarts the period and kills any pending tick.
  always_ff @(posedge Clock) begin
    if (!Reset_n || clr || !en) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (count == LAST);
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
// game_sequencer: play-state FSM, scroll/fall/rise/spawn strobes, collision and BCD score.
`default_nettype none

module game_sequencer
  import game_pkg::*;
#(
  parameter int SCROLL_DIV   = 12500000,
  parameter int FALL_DIV     = 6250000,
  parameter int PIPE_SPACING = 4
) (
  input  logic    Clock,
  input  logic    Reset_n,
  input  logic    start,
  input  logic    flap,
  input  bitmap_t bird,
  input  bitmap_t pipes,
  output logic    scroll_en,
  output logic    fall_en,
  output logic    rise_en,
  output logic    spawn_en,
  output logic    playing,
  output logic    failed,
  output bcd_t    score_tens,
  output bcd_t    score_ones
);

  localparam int SPW = $clog2(PIPE_SPACING);
  localparam logic [SPW-1:0] SP_LAST = SPW'(PIPE_SPACING - 1);

  state_t         state;
  state_t         state_nxt;
  logic           collide;
  logic           run;
  logic           flap_go;
  logic           first_spawn;
  logic [SPW-1:0] spacing;

  assign collide = (state == PLAY) && (|(bird & pipes));
  // A collision cycle must not let any strobe out on the following cycle.
  assign run     = (state == PLAY) && !collide;
  assign flap_go = run && flap;

  always_ff @(posedge Clock) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = PLAY;
      PLAY:    if (collide) state_nxt = CRASH;
      CRASH:                state_nxt = OVER;
      OVER:    if (start)   state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  tick_divider #(.DIV(SCROLL_DIV)) u_scroll_div (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .en      (run),
    .clr     (1'b0),
    .tick    (scroll_en)
  );

  // Flap restarts gravity so the bird hangs a full period after each rise.
  tick_divider #(.DIV(FALL_DIV)) u_fall_div (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .en      (run),
    .clr     (flap_go),
    .tick    (fall_en)
  );

  assign spawn_en = scroll_en && (first_spawn || spacing == SP_LAST);

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      playing     <= 1'b0;
      failed      <= 1'b0;
      rise_en     <= 1'b0;
      first_spawn <= 1'b0;
      spacing     <= '0;
      score_tens  <= 4'd0;
      score_ones  <= 4'd0;
    end else begin
      playing <= (state_nxt == PLAY);
      failed  <= (state_nxt == CRASH);
      rise_en <= flap_go;
      if (state == IDLE && start) begin
        first_spawn <= 1'b1;
        spacing     <= '0;
        score_tens  <= 4'd0;
        score_ones  <= 4'd0;
      end else if (scroll_en) begin
        // The opening pipe does not consume a spacing step and earns no point.
        if (first_spawn) begin
          first_spawn <= 1'b0;
        end else begin
          spacing <= (spacing == SP_LAST) ? '0 : spacing + SPW'(1);
          if (spawn_en) {score_tens, score_ones} <= bcd_inc_sat(score_tens, score_ones);
        end
      end
    end
  end

endmodule

`default_nettype wire
